// File: rtl/servo_move_sequencer_pkg.sv
// Shared types and defaults for the servo move sequencer: direction codes,
// FSM states and the queued command payload.
package servo_move_sequencer_pkg;

  localparam int unsigned PWM_PERIOD_DEF     = 2000000;
  localparam int unsigned FIFO_DEPTH_DEF     = 4;
  localparam int unsigned SETTLE_PERIODS_DEF = 1;

  localparam int unsigned DIR_W     = 2;
  localparam int unsigned PERIODS_W = 16;
  localparam int unsigned CMD_W     = DIR_W + PERIODS_W;
  localparam int unsigned SETTLE_W  = 16;

  typedef enum logic [DIR_W-1:0] {
    DIR_NEUTRAL = 2'b00,
    DIR_FWD     = 2'b01,
    DIR_REV     = 2'b10,
    DIR_ILLEGAL = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_SETTLE = 2'd3
  } state_e;

  typedef struct packed {
    dir_e                 dir;
    logic [PERIODS_W-1:0] periods;
  } cmd_t;

endpackage

// File: rtl/servo_move_sequencer_if.sv
// Move-command handshake between a command source and the sequencer.
interface servo_move_sequencer_if;
  import servo_move_sequencer_pkg::*;

  logic                 cmd_valid;
  logic [DIR_W-1:0]     cmd_dir;
  logic [PERIODS_W-1:0] cmd_periods;
  logic                 cmd_ready;

  modport master (output cmd_valid, output cmd_dir, output cmd_periods, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_dir, input cmd_periods, output cmd_ready);
endinterface

// File: rtl/servo_cmd_fifo.sv
// Synchronous show-ahead command FIFO with occupancy count and flush.
module servo_cmd_fifo
  import servo_move_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 push,
  input  cmd_t                 wdata,
  input  logic                 pop,
  output cmd_t                 rdata_c,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign rdata_c = cmd_t'(mem[rd_ptr]);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/servo_move_sequencer.sv
// Queues servo move commands and replays each as per-frame direction strobes,
// followed by neutral settle frames, aligned to the servo PWM frame.
module servo_move_sequencer
  import servo_move_sequencer_pkg::*;
#(
  parameter int unsigned PWM_PERIOD     = PWM_PERIOD_DEF,
  parameter int unsigned FIFO_DEPTH     = FIFO_DEPTH_DEF,
  parameter int unsigned SETTLE_PERIODS = SETTLE_PERIODS_DEF
) (
  input  logic                        PCLK,
  input  logic                        PRESERN,
  servo_move_sequencer_if.slave       cmd,
  input  logic                        abort,
  output logic                        set_fwd,
  output logic                        set_rev,
  output logic                        set_neutral,
  output logic                        busy,
  output logic                        move_done,
  output logic                        err_illegal,
  output logic [PERIODS_W-1:0]        periods_left,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned TMR_W = $clog2(PWM_PERIOD);
  localparam int unsigned FC_W  = $clog2(FIFO_DEPTH) + 1;

  logic [TMR_W-1:0]    frame_cnt;
  logic                pre_tick;
  logic                push_try;
  logic                cmd_legal;
  logic                fifo_push;
  logic                fifo_pop;
  cmd_t                fifo_head;
  state_e              state;
  dir_e                cur_dir;
  logic [SETTLE_W-1:0] settle_cnt;

  // Free-running frame timer; abort never touches it
  always_ff @(posedge PCLK) begin
    if (PRESERN)                                  frame_cnt <= '0;
    else if (frame_cnt == TMR_W'(PWM_PERIOD - 1)) frame_cnt <= '0;
    else                                          frame_cnt <= frame_cnt + TMR_W'(1);
  end

  // Decisions are made one cycle early so registered strobes land on the tick cycle
  assign pre_tick = (frame_cnt == TMR_W'(PWM_PERIOD - 2));

  assign cmd.cmd_ready = (fifo_count != FC_W'(FIFO_DEPTH));
  assign push_try      = cmd.cmd_valid && cmd.cmd_ready && !abort;
  assign cmd_legal     = (cmd.cmd_dir != DIR_ILLEGAL);
  assign fifo_push     = push_try && cmd_legal;
  assign fifo_pop      = (state == ST_IDLE) && (fifo_count != '0) && !abort;
  assign busy          = (state != ST_IDLE);

  servo_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (PCLK),
    .rst     (PRESERN),
    .flush   (abort),
    .push    (fifo_push),
    .wdata   ('{dir: dir_e'(cmd.cmd_dir), periods: cmd.cmd_periods}),
    .pop     (fifo_pop),
    .rdata_c (fifo_head),
    .count   (fifo_count)
  );

  always_ff @(posedge PCLK) begin
    if (PRESERN) begin
      state        <= ST_IDLE;
      cur_dir      <= DIR_NEUTRAL;
      periods_left <= '0;
      settle_cnt   <= '0;
      set_fwd      <= 1'b0;
      set_rev      <= 1'b0;
      set_neutral  <= 1'b0;
      move_done    <= 1'b0;
      err_illegal  <= 1'b0;
    end else begin
      set_fwd     <= 1'b0;
      set_rev     <= 1'b0;
      set_neutral <= 1'b0;
      move_done   <= 1'b0;
      err_illegal <= push_try && !cmd_legal;
      if (abort) begin
        state        <= ST_IDLE;
        periods_left <= '0;
        settle_cnt   <= '0;
        set_neutral  <= (state == ST_RUN) || (state == ST_SETTLE);
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (fifo_pop) begin
              cur_dir      <= fifo_head.dir;
              periods_left <= fifo_head.periods;
              state        <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            if (periods_left == '0) begin
              move_done <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              state <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (pre_tick) begin
              if (periods_left != '0) begin
                unique case (cur_dir)
                  DIR_FWD: set_fwd     <= 1'b1;
                  DIR_REV: set_rev     <= 1'b1;
                  default: set_neutral <= 1'b1;
                endcase
                periods_left <= periods_left - PERIODS_W'(1);
              end else begin
                set_neutral <= 1'b1;
                settle_cnt  <= SETTLE_W'(SETTLE_PERIODS);
                state       <= ST_SETTLE;
              end
            end
          end
          ST_SETTLE: begin
            // A zero settle count is treated as a single settle frame
            if (pre_tick) begin
              if (settle_cnt <= SETTLE_W'(1)) begin
                settle_cnt <= '0;
                move_done  <= 1'b1;
                state      <= ST_IDLE;
              end else begin
                settle_cnt <= settle_cnt - SETTLE_W'(1);
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_servo_move_sequencer.sv
// Directed self-checking bench for servo_move_sequencer with a 100-cycle frame.
module tb_servo_move_sequencer;

  localparam int PERIOD = 100;

  logic        PCLK;
  logic        PRESERN;
  logic        abort;
  logic        set_fwd;
  logic        set_rev;
  logic        set_neutral;
  logic        busy;
  logic        move_done;
  logic        err_illegal;
  logic [15:0] periods_left;
  logic [2:0]  fifo_count;

  servo_move_sequencer_if bus ();

  servo_move_sequencer #(
    .PWM_PERIOD     (PERIOD),
    .FIFO_DEPTH     (4),
    .SETTLE_PERIODS (1)
  ) dut (
    .PCLK         (PCLK),
    .PRESERN      (PRESERN),
    .cmd          (bus),
    .abort        (abort),
    .set_fwd      (set_fwd),
    .set_rev      (set_rev),
    .set_neutral  (set_neutral),
    .busy         (busy),
    .move_done    (move_done),
    .err_illegal  (err_illegal),
    .periods_left (periods_left),
    .fifo_count   (fifo_count)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int checks   = 0;
  int failures = 0;
  int phase    = 0;
  int cyc      = 0;
  int n_done   = 0;
  int done_cyc = 0;
  int log_code[$];
  int log_cyc[$];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  // One clock: model the frame phase, sample at negedge, log strobes and check their slot
  task automatic step();
    logic ab;
    int   ns;
    ab = abort;
    @(posedge PCLK);
    phase = PRESERN ? 0 : ((phase == PERIOD - 1) ? 0 : phase + 1);
    cyc++;
    @(negedge PCLK);
    ns = int'(set_fwd) + int'(set_rev) + int'(set_neutral);
    if (ns != 0) begin
      chk($sformatf("strobe_slot_phase%0d", phase),
          int'(ns == 1 && (phase == PERIOD - 1 || ab)), 1);
      log_code.push_back(set_fwd ? 1 : (set_rev ? 2 : 3));
      log_cyc.push_back(cyc);
    end
    if (move_done) begin
      n_done++;
      done_cyc = cyc;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_log();
    log_code.delete();
    log_cyc.delete();
  endtask

  task automatic push(input logic [1:0] d, input logic [15:0] p);
    int k;
    k = 0;
    bus.cmd_valid   = 1'b1;
    bus.cmd_dir     = d;
    bus.cmd_periods = p;
    while (!bus.cmd_ready && k < 1000) begin
      step();
      k++;
    end
    chk("push_ready", int'(bus.cmd_ready), 1);
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_dones(input int n, input int budget, input string tag);
    int start;
    int k;
    start = n_done;
    k     = 0;
    while ((n_done - start) < n && k < budget) begin
      step();
      k++;
    end
    chk(tag, n_done - start, n);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_fwd"},       int'(set_fwd), 0);
    chk({tag, "_rev"},       int'(set_rev), 0);
    chk({tag, "_neutral"},   int'(set_neutral), 0);
    chk({tag, "_done"},      int'(move_done), 0);
    chk({tag, "_err"},       int'(err_illegal), 0);
    chk({tag, "_busy"},      int'(busy), 0);
    chk({tag, "_periods"},   int'(periods_left), 0);
    chk({tag, "_count"},     int'(fifo_count), 0);
    chk({tag, "_ready"},     int'(bus.cmd_ready), 1);
  endtask

  int exp_order[13] = '{1, 3, 2, 3, 3, 3, 1, 1, 3, 2, 3, 1, 3};

  initial begin
    int d0;
    int k;
    int ref_cyc;

    PRESERN         = 1'b1;
    abort           = 1'b0;
    bus.cmd_valid   = 1'b0;
    bus.cmd_dir     = 2'b00;
    bus.cmd_periods = 16'd0;
    steps(3);
    chk_reset_outputs("reset");
    PRESERN = 1'b0;
    steps(5);

    // Forward move of 3 frames: three fwd strobes, neutral, then done one frame later
    clear_log();
    push(2'b01, 16'd3);
    chk("fwd3_count_after_push", int'(fifo_count), 1);
    step();
    chk("fwd3_busy_after_pop", int'(busy), 1);
    chk("fwd3_periods_latched", int'(periods_left), 3);
    chk("fwd3_count_after_pop", int'(fifo_count), 0);
    wait_dones(1, 700, "fwd3_done_seen");
    chk("fwd3_busy_with_done", int'(busy), 0);
    chk("fwd3_periods_end", int'(periods_left), 0);
    chk("fwd3_nstrobes", log_code.size(), 4);
    if (log_code.size() == 4) begin
      chk("fwd3_s0", log_code[0], 1);
      chk("fwd3_s1", log_code[1], 1);
      chk("fwd3_s2", log_code[2], 1);
      chk("fwd3_s3", log_code[3], 3);
      chk("fwd3_gap01", log_cyc[1] - log_cyc[0], PERIOD);
      chk("fwd3_gap12", log_cyc[2] - log_cyc[1], PERIOD);
      chk("fwd3_gap23", log_cyc[3] - log_cyc[2], PERIOD);
      chk("fwd3_done_gap", done_cyc - log_cyc[3], PERIOD);
    end
    step();
    chk("fwd3_done_single", int'(move_done), 0);

    // Zero-period reverse move: done two cycles after the pop, no strobes
    clear_log();
    push(2'b10, 16'd0);
    step();
    chk("zero_busy_load", int'(busy), 1);
    chk("zero_done_early", int'(move_done), 0);
    step();
    chk("zero_done", int'(move_done), 1);
    chk("zero_busy_end", int'(busy), 0);
    step();
    chk("zero_done_single", int'(move_done), 0);
    chk("zero_nstrobes", log_code.size(), 0);

    // Illegal direction: dropped with one err pulse
    clear_log();
    push(2'b11, 16'd7);
    chk("illegal_err", int'(err_illegal), 1);
    chk("illegal_count", int'(fifo_count), 0);
    step();
    chk("illegal_err_single", int'(err_illegal), 0);
    chk("illegal_busy", int'(busy), 0);
    steps(250);
    chk("illegal_nstrobes", log_code.size(), 0);

    // Back-to-back pushes while running: fills, back-pressures, all run in order
    clear_log();
    push(2'b01, 16'd1);
    steps(2);
    d0 = n_done;
    push(2'b10, 16'd1);
    push(2'b00, 16'd1);
    push(2'b01, 16'd2);
    push(2'b10, 16'd1);
    chk("fill_count", int'(fifo_count), 4);
    chk("fill_ready_low", int'(bus.cmd_ready), 0);
    push(2'b01, 16'd1);
    chk("fill_fifth_count", int'(fifo_count), 4);
    chk("fill_fifth_waited", n_done - d0, 1);
    wait_dones(5, 3000, "fill_all_done");
    chk("fill_nstrobes", log_code.size(), 13);
    for (int i = 0; i < 13; i++)
      chk($sformatf("fill_order%0d", i), (i < log_code.size()) ? log_code[i] : -1, exp_order[i]);
    chk("fill_idle", int'(busy), 0);

    // Abort mid-run with two queued and a simultaneous push
    clear_log();
    push(2'b01, 16'd5);
    k = 0;
    while (log_code.size() == 0 && k < 300) begin
      step();
      k++;
    end
    chk("abort_first_strobe", log_code.size(), 1);
    ref_cyc = (log_code.size() > 0) ? log_cyc[0] : 0;
    push(2'b10, 16'd1);
    push(2'b01, 16'd1);
    chk("abort_queued", int'(fifo_count), 2);
    d0 = n_done;
    abort           = 1'b1;
    bus.cmd_valid   = 1'b1;
    bus.cmd_dir     = 2'b01;
    bus.cmd_periods = 16'd9;
    step();
    abort         = 1'b0;
    bus.cmd_valid = 1'b0;
    chk("abort_neutral", int'(set_neutral), 1);
    chk("abort_fwd", int'(set_fwd), 0);
    chk("abort_count", int'(fifo_count), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_periods", int'(periods_left), 0);
    chk("abort_no_done", int'(move_done), 0);
    step();
    chk("abort_neutral_single", int'(set_neutral), 0);
    steps(20);
    chk("abort_no_done_later", n_done - d0, 0);
    chk("abort_push_dropped", int'(fifo_count), 0);
    chk("abort_stays_idle", int'(busy), 0);
    clear_log();
    push(2'b01, 16'd1);
    wait_dones(1, 500, "abort_after_done");
    chk("abort_after_s0", (log_code.size() > 0) ? log_code[0] : -1, 1);
    chk("abort_timer_phase", (log_cyc.size() > 0) ? (log_cyc[0] - ref_cyc) % PERIOD : -1, 0);

    // Reset during settle: outputs return to reset values at once, no strobe
    clear_log();
    push(2'b01, 16'd1);
    k = 0;
    while (log_code.size() < 2 && k < 500) begin
      step();
      k++;
    end
    chk("settle_reached", log_code.size(), 2);
    chk("settle_busy", int'(busy), 1);
    steps(5);
    d0 = n_done;
    PRESERN = 1'b1;
    step();
    chk_reset_outputs("mid_reset");
    step();
    chk("mid_reset_no_strobe", log_code.size(), 2);
    PRESERN = 1'b0;
    steps(200);
    chk("mid_reset_no_done", n_done - d0, 0);
    chk("mid_reset_no_strobe_after", log_code.size(), 2);
    clear_log();
    push(2'b10, 16'd1);
    wait_dones(1, 500, "post_reset_done");
    chk("post_reset_nstrobes", log_code.size(), 2);
    chk("post_reset_s0", (log_code.size() > 0) ? log_code[0] : -1, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
